// File: rtl/mac_result_collector_if.sv
// Result stream from the collector toward the output-matrix writer:
// valid/ready handshake carrying one signed dot product and its row-end flag.
interface mac_result_collector_if #(
   parameter int RESULT_SIZE = 32
);
   logic                          o_valid;
   logic                          o_ready;
   logic signed [RESULT_SIZE-1:0] o_data;
   logic                          o_last;

   modport master (
      output o_valid,
      output o_data,
      output o_last,
      input  o_ready
   );

   modport slave (
      input  o_valid,
      input  o_data,
      input  o_last,
      output o_ready
   );
endinterface

// File: rtl/mac_result_collector.sv
// mac_result_collector: mirrors the mul_add pipeline using its start strobe,
// captures each completed dot product once, and buffers it in a small FIFO
// with row framing, an almost-full hint and a sticky overflow flag.
`ifndef RESULT_SIZE
`define RESULT_SIZE 32
`endif

module mac_result_collector #(
   parameter int RESULT_SIZE = `RESULT_SIZE,
   parameter int FIFO_DEPTH  = 4,
   parameter int AF_THRESH   = 1,
   parameter int ROW_LEN     = 8
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          mac_start,
   input  logic signed [RESULT_SIZE-1:0] mac_result,
   input  logic                          mac_finish,
   mac_result_collector_if.master        res,
   output logic                          almost_full,
   output logic                          overflow,
   input  logic                          clr_overflow
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ROW_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(ROW_LEN - 1);

   typedef struct packed {
      logic                          last;
      logic signed [RESULT_SIZE-1:0] data;
   } entry_t;

   logic [3:0]       tag;
   logic [ROW_W-1:0] row;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   entry_t           mem [FIFO_DEPTH];

   logic capture;
   logic pop;
   logic full;
   logic push;
   logic drop;
   logic row_last;

   // tag[3] is high in the cycle after the MAC accumulates a start beat;
   // together with the finish level it marks a freshly completed vector.
   assign capture  = tag[3] & mac_finish;
   assign full     = (count == FULL_CNT);
   assign pop      = res.o_valid & res.o_ready;
   assign push     = capture & (~full | pop);
   assign drop     = capture & full & ~pop;
   assign row_last = (row == ROW_END);

   assign res.o_valid = (count != '0);
   assign res.o_data  = mem[rd_ptr].data;
   assign res.o_last  = mem[rd_ptr].last;
   assign almost_full = (FIFO_DEPTH - int'(count)) <= AF_THRESH;

   // Shadow of the MAC's start pipeline, shifted every cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) tag <= '0;
      else       tag <= {tag[2:0], mac_start};
   end

   // Row position advances on every capture, dropped or not, so framing
   // stays aligned with the compute array.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        row <= '0;
      else if (capture) row <= row_last ? '0 : row + ROW_W'(1);
   end

   // FIFO storage, pointers and occupancy; entries are cleared on reset so
   // the head reads zero until the first push.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{last: row_last, data: mac_result};
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow: a drop sets it and takes priority over a clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)             overflow <= 1'b0;
      else if (drop)         overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
   end
endmodule
